ff_sync_filter: RTL and testbench
=================================

Name: ff_sync_filter

Overview:
- Multi-channel successor to the single-bit FF synchronizer.
- Synchronises CHANNELS independent asynchronous inputs through a SYNC_REGS-deep flop chain, then applies a per-channel glitch filter.
- Provides debounced levels plus single-cycle rise/fall strobes.
- Sits at the boundary between external pins or foreign clock domains and local control logic: buttons, status lines, slow handshake levels.

Parameters:
- CHANNELS, 8: number of independent 1-bit channels; must be >= 1.
- SYNC_REGS, 3: synchroniser depth per channel; must be >= 2.
- FILTER_CYCLES, 4: consecutive cycles a synchronised value must persist before data_o takes it; must be >= 1.
- RESET_VAL, {CHANNELS{1'b0}}: per-channel reset level for the sync chain and data_o.

Ports:
- clk_i  in  1  Single clock for the whole block.
- rst_i  in  1  Reset, synchronous, active-high.
- filter_en_i  in  1  1 = glitch filter active; 0 = bypass (data_o follows the synchronised value with 1-cycle latency).
- data_i  in  CHANNELS  Asynchronous inputs.
- data_o  out  CHANNELS  Filtered, synchronised levels.
- rise_o  out  CHANNELS  One-cycle strobe when data_o[n] goes 0->1.
- fall_o  out  CHANNELS  One-cycle strobe when data_o[n] goes 1->0.
- any_change_o  out  1  OR of (rise_o | fall_o), same cycle.

Behaviour:
- Reset (rst_i=1 at a posedge):
  - All sync stages <= RESET_VAL.
  - data_o <= RESET_VAL.
  - All counters <= 0.
  - rise_o, fall_o, any_change_o <= 0.
  - Applies mid-operation too: a partially counted transition is discarded.
  - No strobes are generated in the reset cycle.
- Sync chain:
  - Per channel, a shift register of SYNC_REGS flops.
  - Stage 0 samples data_i[n]; stage SYNC_REGS-1 gives s[n].
  - Stages carry ASYNC_REG / no-SRL-extraction attributes.
  - No logic between stages.
- Filter, filter_en_i=1, per channel:
  - Counter cnt[n], width $clog2(FILTER_CYCLES+1).
  - If s[n]==data_o[n]: cnt <= 0.
  - If s[n]!=data_o[n] and cnt < FILTER_CYCLES-1: cnt <= cnt+1.
  - If s[n]!=data_o[n] and cnt == FILTER_CYCLES-1: data_o[n] <= s[n], cnt <= 0.
  - A mismatch lasting fewer than FILTER_CYCLES consecutive cycles never reaches data_o.
  - Any cycle of agreement restarts the count from 0.
- Bypass, filter_en_i=0:
  - data_o <= s each cycle; cnt held at 0.
  - Toggling filter_en_i takes effect at the next edge.
  - On re-enable, counters start from 0.
- Latency: data_i stable from before edge 1 gives:
  - s at edge SYNC_REGS.
  - data_o at edge SYNC_REGS+FILTER_CYCLES (filter on).
  - data_o at edge SYNC_REGS+1 (bypass).
- Strobes:
  - Registered, asserted on the same edge data_o updates, for exactly one cycle.
  - rise_o[n] = new 1 and old 0; fall_o[n] = new 0 and old 1.
  - Never both set on the same channel.
- Channels are fully independent.
  - Simultaneous transitions on several channels give simultaneous strobes.
  - any_change_o is single-cycle even if many channels change.

Test Plan:
- Defaults, reset then data_i=8'h00 for 10 cycles -> data_o=8'h00, no strobes; then data_i[0] 0->1 held -> data_o[0]=1 and rise_o=8'h01 for one cycle, exactly 7 edges after the step; any_change_o=1 in that cycle only.
- data_i[1] pulses high for 3 cycles -> data_o[1] stays 0, no strobes. Pulse of exactly 4 cycles -> data_o[1]=1 for at least 1 cycle, then fall_o[1] once it drops, with no extra strobes.
- filter_en_i=0, data_i[2] toggles every 2 cycles -> data_o[2] follows with SYNC_REGS+1=4-cycle latency, with a rise or fall strobe on each transition.
- data_i=8'hFF step from 8'h00 -> all data_o bits rise on the same edge, rise_o=8'hFF for one cycle, any_change_o one cycle.
- Assert rst_i one cycle after data_o[3] begins counting toward a 0->1 transition, with data_i[3] held 1 -> data_o=RESET_VAL and no strobe on the reset edge; after release, data_o[3] rises 7 edges later.
- RESET_VAL=8'hF0, reset with data_i=8'hF0 -> data_o=8'hF0 and no strobes at any time.

Source files
------------

// File: rtl/ff_sync_filter_if.sv
// ff_sync_filter_if: data/strobe bundle for the multi-channel synchroniser
// and glitch filter.
//   filter_en_i  : 1 = glitch filter active, 0 = bypass
//   data_i       : asynchronous channel inputs
//   data_o       : filtered, synchronised levels
//   rise_o/fall_o: one-cycle edge strobes per channel
//   any_change_o : OR of all strobes
// master drives the inputs; slave is the filter block.
interface ff_sync_filter_if #(
  parameter int CHANNELS = 8
);
  logic                filter_en_i;
  logic [CHANNELS-1:0] data_i;
  logic [CHANNELS-1:0] data_o;
  logic [CHANNELS-1:0] rise_o;
  logic [CHANNELS-1:0] fall_o;
  logic                any_change_o;

  modport master (
    output filter_en_i, data_i,
    input  data_o, rise_o, fall_o, any_change_o
  );

  modport slave (
    input  filter_en_i, data_i,
    output data_o, rise_o, fall_o, any_change_o
  );
endinterface

// File: rtl/ff_sync_filter.sv
// ff_sync_filter: CHANNELS independent asynchronous inputs, each passed
// through a SYNC_REGS-deep synchroniser and then a glitch filter that only
// accepts a new level after it persists FILTER_CYCLES consecutive cycles.
// Registered rise/fall strobes accompany every change of data_o.
//   clk_i : single clock
//   rst_i : synchronous, active-high reset
//   bus   : ff_sync_filter_if.slave (filter_en_i, data_i in;
//           data_o, rise_o, fall_o, any_change_o out)
// Parameter constraints: CHANNELS >= 1, SYNC_REGS >= 2, FILTER_CYCLES >= 1.

// One channel: synchroniser chain, persistence counter, level and strobes.
module ff_sync_filter_lane #(
  parameter int   SYNC_REGS     = 3,
  parameter int   FILTER_CYCLES = 4,
  parameter logic RST_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic filter_en,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);
  localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FILTER_CYCLES - 1);

  // Pure flop chain: keep the stages together and out of shift-register
  // primitives so the metastability settling time is not eroded.
  (* ASYNC_REG = "TRUE", shreg_extract = "no" *)
  logic [SYNC_REGS-1:0] sync;

  logic             s;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lvl_nxt;

  assign s = sync[SYNC_REGS-1];

  always_ff @(posedge clk) begin
    if (rst) sync <= {SYNC_REGS{RST_VAL}};
    else     sync <= {sync[SYNC_REGS-2:0], din};
  end

  // The counter tracks consecutive cycles of disagreement; any agreement,
  // an accepted change, or bypass mode puts it back to zero.
  always_comb begin
    lvl_nxt = dout;
    cnt_nxt = '0;
    if (!filter_en) begin
      lvl_nxt = s;
    end else if (s != dout) begin
      if (cnt == LAST) lvl_nxt = s;
      else             cnt_nxt = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= RST_VAL;
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      dout <= lvl_nxt;
      cnt  <= cnt_nxt;
      rise <= lvl_nxt & ~dout;
      fall <= ~lvl_nxt & dout;
    end
  end
endmodule

module ff_sync_filter #(
  parameter int                CHANNELS      = 8,
  parameter int                SYNC_REGS     = 3,
  parameter int                FILTER_CYCLES = 4,
  parameter logic [CHANNELS-1:0] RESET_VAL   = {CHANNELS{1'b0}}
) (
  input  logic              clk_i,
  input  logic              rst_i,
  ff_sync_filter_if.slave   bus
);
  logic [CHANNELS-1:0] lvl, rise, fall;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    ff_sync_filter_lane #(
      .SYNC_REGS    (SYNC_REGS),
      .FILTER_CYCLES(FILTER_CYCLES),
      .RST_VAL      (RESET_VAL[g])
    ) u_lane (
      .clk      (clk_i),
      .rst      (rst_i),
      .filter_en(bus.filter_en_i),
      .din      (bus.data_i[g]),
      .dout     (lvl[g]),
      .rise     (rise[g]),
      .fall     (fall[g])
    );
  end

  assign bus.data_o       = lvl;
  assign bus.rise_o       = rise;
  assign bus.fall_o       = fall;
  // Strobes are already registered and one cycle wide, so the OR is too.
  assign bus.any_change_o = |(rise | fall);
endmodule

// File: tb/tb_ff_sync_filter.sv
module tb_ff_sync_filter;
  localparam int CH = 8;
  localparam int SR = 3;
  localparam int FC = 4;
  localparam logic [CH-1:0] RV0 = 8'h00;
  localparam logic [CH-1:0] RV1 = 8'hF0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ff_sync_filter_if #(.CHANNELS(CH)) bus0 ();
  ff_sync_filter_if #(.CHANNELS(CH)) bus1 ();

  ff_sync_filter #(.CHANNELS(CH), .SYNC_REGS(SR), .FILTER_CYCLES(FC), .RESET_VAL(RV0))
    dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0.slave));
  ff_sync_filter #(.CHANNELS(CH), .SYNC_REGS(SR), .FILTER_CYCLES(FC), .RESET_VAL(RV1))
    dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1.slave));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: data_o changes only when the synchronised value has
  // disagreed with it on each of the last FC edges since the most recent
  // restart (reset, acceptance, or bypass edge).
  logic [CH-1:0] sq[$];          // data_i samples since reset, newest last
  logic [CH-1:0] shist[int];     // synchronised value seen at each edge
  int            last_evt[CH];
  int            ecount = 0;
  bit            m_valid = 0;
  logic [CH-1:0] m_out = RV0, m_rise = '0, m_fall = '0;

  task automatic model_edge(input logic [CH-1:0] din, input logic en, input logic r);
    logic [CH-1:0] s, old;
    bit all_mis;
    ecount++;
    s = (sq.size() == SR) ? sq[0] : RV0;
    shist[ecount] = s;
    old = m_out;
    if (r) begin
      sq.delete();
      m_out = RV0;
      for (int n = 0; n < CH; n++) last_evt[n] = ecount;
      m_rise = '0;
      m_fall = '0;
      m_valid = 1;
      return;
    end
    for (int n = 0; n < CH; n++) begin
      if (!en) begin
        m_out[n] = s[n];
        last_evt[n] = ecount;
      end else if (ecount - last_evt[n] >= FC) begin
        all_mis = 1;
        for (int k = 0; k < FC; k++)
          if (shist[ecount-k][n] == old[n]) all_mis = 0;
        if (all_mis) begin
          m_out[n] = s[n];
          last_evt[n] = ecount;
        end
      end
    end
    m_rise = m_out & ~old;
    m_fall = ~m_out & old;
    sq.push_back(din);
    if (sq.size() > SR) void'(sq.pop_front());
  endtask

  // One clock: drive at negedge, model on posedge, compare 1 time unit later.
  task automatic cyc(input logic [CH-1:0] din, input logic en, input logic r);
    @(negedge clk);
    bus0.data_i = din;
    bus0.filter_en_i = en;
    rst = r;
    @(posedge clk);
    model_edge(din, en, r);
    #1;
    if (m_valid) begin
      chk("model data_o", bus0.data_o, m_out);
      chk("model rise_o", bus0.rise_o, m_rise);
      chk("model fall_o", bus0.fall_o, m_fall);
      chk("model any_change_o", bus0.any_change_o, |(m_rise | m_fall));
      chk("rv_f0 data_o", bus1.data_o, RV1);
      chk("rv_f0 strobes", {bus1.rise_o, bus1.fall_o, 7'd0, bus1.any_change_o}, 24'd0);
    end
  endtask

  typedef struct {
    logic [CH-1:0] din;
    logic [CH-1:0] exp_do;
    logic [CH-1:0] exp_rise;
    logic [CH-1:0] exp_fall;
    logic          exp_any;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int rep, input logic [CH-1:0] din, input logic [CH-1:0] d,
                     input logic [CH-1:0] rs, input logic [CH-1:0] fl, input logic an);
    vec_t v;
    v.din = din; v.exp_do = d; v.exp_rise = rs; v.exp_fall = fl; v.exp_any = an;
    for (int i = 0; i < rep; i++) tbl.push_back(v);
  endtask

  initial begin
    logic [CH-1:0] d;
    logic en;
    bit seen;
    int n_seen;

    bus0.data_i = '0; bus0.filter_en_i = 1'b1;
    bus1.data_i = RV1; bus1.filter_en_i = 1'b1;

    cyc(8'h00, 1'b1, 1'b1);
    chk("reset data_o", bus0.data_o, 8'h00);
    chk("reset strobes", {bus0.rise_o, bus0.fall_o, 7'd0, bus0.any_change_o}, 24'd0);
    cyc(8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc(8'h00, 1'b1, 1'b0);
      chk("idle data_o", bus0.data_o, 8'h00);
    end

    // 0->1 step on ch0, 3- and 4-cycle pulses on ch1, fall to 0, all-channel rise
    add(6, 8'h01, 8'h00, 8'h00, 8'h00, 0); add(1, 8'h01, 8'h01, 8'h01, 8'h00, 1);
    add(3, 8'h01, 8'h01, 8'h00, 8'h00, 0);
    add(3, 8'h03, 8'h01, 8'h00, 8'h00, 0); add(8, 8'h01, 8'h01, 8'h00, 8'h00, 0);
    add(4, 8'h03, 8'h01, 8'h00, 8'h00, 0); add(2, 8'h01, 8'h01, 8'h00, 8'h00, 0);
    add(1, 8'h01, 8'h03, 8'h02, 8'h00, 1); add(3, 8'h01, 8'h03, 8'h00, 8'h00, 0);
    add(1, 8'h01, 8'h01, 8'h00, 8'h02, 1); add(2, 8'h01, 8'h01, 8'h00, 8'h00, 0);
    add(6, 8'h00, 8'h01, 8'h00, 8'h00, 0); add(1, 8'h00, 8'h00, 8'h00, 8'h01, 1);
    add(3, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    add(6, 8'hFF, 8'h00, 8'h00, 8'h00, 0); add(1, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1);
    add(3, 8'hFF, 8'hFF, 8'h00, 8'h00, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].din, 1'b1, 1'b0);
      chk($sformatf("vec%0d data_o", i), bus0.data_o, tbl[i].exp_do);
      chk($sformatf("vec%0d rise_o", i), bus0.rise_o, tbl[i].exp_rise);
      chk($sformatf("vec%0d fall_o", i), bus0.fall_o, tbl[i].exp_fall);
      chk($sformatf("vec%0d any", i), bus0.any_change_o, tbl[i].exp_any);
    end

    // Bypass: data_i[2] toggles every 2 cycles; 4-edge latency
    for (int i = 0; i < 12; i++) cyc(8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      cyc(((i / 2) % 2 == 0) ? 8'h04 : 8'h00, 1'b0, 1'b0);
      if (i == 2) chk("bypass before latency", bus0.data_o, 8'h00);
      if (i == 3) begin
        chk("bypass latency data_o", bus0.data_o, 8'h04);
        chk("bypass latency rise_o", bus0.rise_o, 8'h04);
      end
    end
    for (int i = 0; i < 12; i++) cyc(8'h00, 1'b1, 1'b0);

    // Reset while ch3 is counting toward a rise
    for (int i = 0; i < 4; i++) cyc(8'h08, 1'b1, 1'b0);
    cyc(8'h08, 1'b1, 1'b1);
    chk("midreset data_o", bus0.data_o, 8'h00);
    chk("midreset strobes", {bus0.rise_o, bus0.fall_o, 7'd0, bus0.any_change_o}, 24'd0);
    seen = 0; n_seen = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      cyc(8'h08, 1'b1, 1'b0);
      if (bus0.data_o[3]) begin
        seen = 1; n_seen = i;
        chk("postreset rise_o", bus0.rise_o, 8'h08);
      end
    end
    chk("postreset rise edge count", n_seen, 7);

    // Randomized: slow per-channel flips, occasional bypass and reset
    d = 8'h00; en = 1'b1;
    for (int i = 0; i < 800; i++) begin
      for (int n = 0; n < CH; n++)
        if ($urandom_range(0, 5) == 0) d[n] = ~d[n];
      if ($urandom_range(0, 40) == 0) en = ~en;
      cyc(d, en, ($urandom_range(0, 150) == 0));
    end
    for (int i = 0; i < 10; i++) cyc(d, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
